sr_ff_bank: RTL
===============

SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent SR channels (1..32).
REQ-002 SHALL have parameter MODE, default 0, S=R=1 resolution: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
REQ-003 SHALL have parameter CNT_W, default 8, width of invalid-event counter.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port S, input, WIDTH, per-channel set request.
REQ-008 SHALL have port R, input, WIDTH, per-channel reset request.
REQ-009 SHALL have port en, input, 1, global update enable.
REQ-010 SHALL have port Q, output, WIDTH, channel state.
REQ-011 SHALL have port Q_not, output, WIDTH, always bitwise inverse of Q.
REQ-012 SHALL have port invalid, output, WIDTH, registered per-channel S=R=1 indicator.
REQ-013 SHALL have port invalid_cnt, output, CNT_W, saturating count of invalid cycles.

Function
REQ-014 On each rising clk with en=1, each channel SHALL update: S=0,R=0 hold; S=0,R=1 Q<=0; S=1,R=0 Q<=1; S=1,R=1 per MODE.
REQ-015 With en=0, Q SHALL hold, invalid SHALL clear to 0, and invalid_cnt SHALL hold.
REQ-016 Q update latency SHALL be one clock; no combinational path from S/R to Q.
REQ-017 invalid[i] SHALL be 1 for exactly the cycle after an en=1 edge sampling S[i]=R[i]=1, for every MODE.
REQ-018 invalid_cnt SHALL increment by 1 per en=1 edge where any channel has S=R=1, regardless of how many channels.
REQ-019 invalid_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 MODE=3 SHALL invert Q on S=R=1; consecutive S=R=1 cycles SHALL toggle every cycle.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-022 Illegal MODE values (>3) SHALL behave as MODE 0.

Reset
REQ-023 rst=1 SHALL immediately force Q=0, Q_not=all-ones, invalid=0, invalid_cnt=0, without a clock.
REQ-024 Reset asserted mid-operation SHALL override any S/R activity in the same cycle.
REQ-025 First update after rst deasserts SHALL occur on the first rising clk with rst=0.

Configuration
REQ-026 Macro SR_FF_BANK_STICKY_ERR_EN, when defined, SHALL add input err_clr (1 bit) and output err_sticky (WIDTH), set per channel on any invalid event, cleared to 0 by err_clr on the next edge, set winning over clear in the same cycle, reset to 0.
REQ-027 Without SR_FF_BANK_STICKY_ERR_EN, neither port nor its logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package sr_pkg SHALL hold the mode constants (MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_HOLD=2, MODE_TOGGLE=3).
REQ-029 Sub-module sr_ff_cell SHALL implement one channel (Q, invalid), instantiated WIDTH times via generate; counter and sticky logic SHALL live in sr_ff_bank.

Verification
REQ-030 Reset: rst=1 asynchronously mid-cycle with Q=4'b1010 -> Q=4'b0000, Q_not=4'b1111, invalid_cnt=0 before next clk.
REQ-031 Basic: MODE=0, en=1, S=4'b0011,R=4'b0100 one cycle, then S=R=0 -> Q=4'b0011 after one edge and holds.
REQ-032 Priority: S=R=4'b0001 from Q=0 -> MODE0 Q[0]=0, MODE1 Q[0]=1, MODE2 Q[0]=0, MODE3 toggles 1,0,1 over three cycles; invalid=4'b0001 each following cycle.
REQ-033 Saturation: CNT_W=2, five invalid cycles -> invalid_cnt 1,2,3,3,3.
REQ-034 Enable: en=0 with S=4'b1111 -> Q unchanged, invalid=0, invalid_cnt unchanged.
REQ-035 Sticky (macro on): invalid on channel 2, then err_clr with simultaneous new channel-2 invalid -> err_sticky[2] stays 1; err_clr alone next cycle -> 0.

Source files
------------

// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_pkg
// Description : Shared mode constants for the SR flip-flop bank.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

    localparam int MODE_RST_DOM = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_HOLD    = 2;
    localparam int MODE_TOGGLE  = 3;

    // Out-of-range mode values fall back to reset-dominant behaviour.
    function automatic int resolve_mode(input int mode);
        if (mode >= MODE_RST_DOM && mode <= MODE_TOGGLE) begin
            return mode;
        end
        return MODE_RST_DOM;
    endfunction

endpackage : sr_pkg
`default_nettype wire

// File: rtl/sr_ff_cell.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_cell
// Description : One SR channel with registered state and S=R=1 indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_cell
    import sr_pkg::*;
#(
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic invalid
);

    localparam int c_MODE = resolve_mode(MODE);

    logic r_q;
    logic r_invalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= 1'b0;
            r_invalid <= 1'b0;
        end else if (en) begin
            r_invalid <= s & r;
            case ({s, r})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11: begin
                    case (c_MODE)
                        MODE_SET_DOM: r_q <= 1'b1;
                        MODE_HOLD:    r_q <= r_q;
                        MODE_TOGGLE:  r_q <= ~r_q;
                        default:      r_q <= 1'b0;
                    endcase
                end
                default: r_q <= r_q;
            endcase
        end else begin
            // Disabled cycles hold state but never flag an invalid request.
            r_invalid <= 1'b0;
        end
    end

    assign q       = r_q;
    assign invalid = r_invalid;

endmodule : sr_ff_cell
`default_nettype wire

// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_bank
// Description : Bank of WIDTH independent SR flip-flops with a saturating
//               invalid-event counter. Optional sticky per-channel error flags
//               are enabled by defining SR_FF_BANK_STICKY_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_not,
    output logic [WIDTH-1:0] invalid,
    output logic [CNT_W-1:0] invalid_cnt
`ifdef SR_FF_BANK_STICKY_ERR_EN
    ,
    input  logic             err_clr,
    output logic [WIDTH-1:0] err_sticky
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_event;
    logic             w_any_event;
    logic [CNT_W-1:0] r_cnt;

    // Channels flagging S=R=1 on an enabled edge.
    assign w_event     = {WIDTH{en}} & S & R;
    assign w_any_event = |w_event;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_ff_cell #(
            .MODE(MODE)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .s       (S[g]),
            .r       (R[g]),
            .q       (Q[g]),
            .invalid (invalid[g])
        );
    end

    assign Q_not = ~Q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_any_event && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign invalid_cnt = r_cnt;

`ifdef SR_FF_BANK_STICKY_ERR_EN
    logic [WIDTH-1:0] r_sticky;

    // A new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (err_clr ? '0 : r_sticky) | w_event;
        end
    end

    assign err_sticky = r_sticky;
`endif

endmodule : sr_ff_bank
`default_nettype wire
